// File: rtl/rsa_op_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rsa_op_loader
//  Purpose  : Operand entry controller for the RSA demo board. Each accepted
//             press of the load pushbutton shifts the 8-bit toggle-switch value
//             into the current operand, most significant byte first. The
//             operands are loaded in the order M, E, then N. The block then
//             starts the RSA core and waits for it to finish. When the core
//             is done, it pulses the select line of the display controller.
//
//  Ports    : ld_clk    in   1  system clock (rising edge)
//             ld_rst    in   1  synchronous active-high reset
//             ld_din    in   8  toggle switches (asynchronous, read on capture)
//             ld_btn    in   1  load pushbutton (asynchronous, bouncy)
//             ld_done   in   1  core completion, only looked at while BUSY
//             ld_m      out  W  message operand   (W = 8*NBYTES)
//             ld_e      out  W  exponent operand
//             ld_n      out  W  modulus operand
//             ld_start  out  1  one-cycle core start pulse
//             ld_busy   out  1  high while the core is being started or runs
//             ld_sel    out  1  one-cycle select pulse to display controller
//             ld_field  out  2  0=M, 1=E, 2=N, 3=run
//
//  Config   : RSA_LD_DEBOUNCE_EN - when defined, a DEB_CYCLES-sample
//             debouncer follows the synchronizer. When undefined, the
//             synchronized button level is used directly.
//
//  Revision : 1.0  initial release
// ============================================================================
module rsa_op_loader #(
    parameter int NBYTES     = 1,
    parameter int DEB_CYCLES = 16
) (
    input  logic                  ld_clk,
    input  logic                  ld_rst,
    input  logic [7:0]            ld_din,
    input  logic                  ld_btn,
    input  logic                  ld_done,
    output logic [8*NBYTES-1:0]   ld_m,
    output logic [8*NBYTES-1:0]   ld_e,
    output logic [8*NBYTES-1:0]   ld_n,
    output logic                  ld_start,
    output logic                  ld_busy,
    output logic                  ld_sel,
    output logic [1:0]            ld_field
);

    localparam int c_W     = 8 * NBYTES;
    localparam int c_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NBYTES - 1);

    localparam logic [2:0] c_ST_LOAD_M = 3'd0;
    localparam logic [2:0] c_ST_LOAD_E = 3'd1;
    localparam logic [2:0] c_ST_LOAD_N = 3'd2;
    localparam logic [2:0] c_ST_START  = 3'd3;
    localparam logic [2:0] c_ST_BUSY   = 3'd4;

    // ------------------------------------------------------------------
    // Button path: synchronizer -> (debouncer) -> rising-edge accept
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_q;
    logic r_q_prev;
    logic w_acc;

    always_ff @(posedge ld_clk) begin
        if (ld_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= ld_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef RSA_LD_DEBOUNCE_EN
    localparam int c_CNT_W = $clog2(DEB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_q;
    logic [c_CNT_W-1:0] r_cnt;

    // A level change is accepted only after DEB_CYCLES consecutive samples
    // that disagree with the current stable level. Any agreeing sample
    // restarts the count.
    always_ff @(posedge ld_clk) begin
        if (ld_rst) begin
            r_q   <= 1'b0;
            r_cnt <= '0;
        end else if (r_sync2 == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_q   <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_q = r_q;
`else
    assign w_q = r_sync2;
`endif

    always_ff @(posedge ld_clk) begin
        if (ld_rst) begin
            r_q_prev <= 1'b0;
        end else begin
            r_q_prev <= w_q;
        end
    end

    assign w_acc = w_q & ~r_q_prev;

    // ------------------------------------------------------------------
    // Operand shift values (new byte enters at the LSB end)
    // ------------------------------------------------------------------
    logic [c_W-1:0] r_m;
    logic [c_W-1:0] r_e;
    logic [c_W-1:0] r_n;
    logic [c_W-1:0] w_shift_m;
    logic [c_W-1:0] w_shift_e;
    logic [c_W-1:0] w_shift_n;

    generate
        if (NBYTES == 1) begin : g_single_byte
            assign w_shift_m = ld_din;
            assign w_shift_e = ld_din;
            assign w_shift_n = ld_din;
        end else begin : g_multi_byte
            assign w_shift_m = {r_m[c_W-9:0], ld_din};
            assign w_shift_e = {r_e[c_W-9:0], ld_din};
            assign w_shift_n = {r_n[c_W-9:0], ld_din};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] w_next_idx;
    logic               w_cap_m;
    logic               w_cap_e;
    logic               w_cap_n;
    logic               w_start_nxt;
    logic               w_sel_nxt;
    logic               w_busy_nxt;
    logic [1:0]         w_field_nxt;

    logic               r_start;
    logic               r_busy;
    logic               r_sel;
    logic [1:0]         r_field;

    always_ff @(posedge ld_clk) begin
        if (ld_rst) begin
            r_state <= c_ST_LOAD_M;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_cap_m      = 1'b0;
        w_cap_e      = 1'b0;
        w_cap_n      = 1'b0;
        w_start_nxt  = 1'b0;
        w_sel_nxt    = 1'b0;

        case (r_state)
            c_ST_LOAD_M: begin
                if (w_acc) begin
                    w_cap_m = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_next_idx   = '0;
                        w_next_state = c_ST_LOAD_E;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                    end
                end
            end
            c_ST_LOAD_E: begin
                if (w_acc) begin
                    w_cap_e = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_next_idx   = '0;
                        w_next_state = c_ST_LOAD_N;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                    end
                end
            end
            c_ST_LOAD_N: begin
                if (w_acc) begin
                    w_cap_n = 1'b1;
                    if (r_idx == c_IDX_LAST) begin
                        w_next_idx   = '0;
                        w_next_state = c_ST_START;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                    end
                end
            end
            c_ST_START: begin
                // Presses here and in BUSY are dropped on purpose, so the
                // operands stay fixed while the core runs.
                w_start_nxt  = 1'b1;
                w_next_state = c_ST_BUSY;
            end
            c_ST_BUSY: begin
                if (ld_done) begin
                    w_sel_nxt    = 1'b1;
                    w_next_idx   = '0;
                    w_next_state = c_ST_LOAD_M;
                end
            end
            default: begin
                w_next_idx   = '0;
                w_next_state = c_ST_LOAD_M;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register.
        w_busy_nxt = (w_next_state == c_ST_START) || (w_next_state == c_ST_BUSY);
        case (w_next_state)
            c_ST_LOAD_M: w_field_nxt = 2'd0;
            c_ST_LOAD_E: w_field_nxt = 2'd1;
            c_ST_LOAD_N: w_field_nxt = 2'd2;
            default:     w_field_nxt = 2'd3;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs and operand registers
    // ------------------------------------------------------------------
    always_ff @(posedge ld_clk) begin
        if (ld_rst) begin
            r_m     <= '0;
            r_e     <= '0;
            r_n     <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_sel   <= 1'b0;
            r_field <= 2'd0;
        end else begin
            if (w_cap_m) r_m <= w_shift_m;
            if (w_cap_e) r_e <= w_shift_e;
            if (w_cap_n) r_n <= w_shift_n;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_sel   <= w_sel_nxt;
            r_field <= w_field_nxt;
        end
    end

    assign ld_m     = r_m;
    assign ld_e     = r_e;
    assign ld_n     = r_n;
    assign ld_start = r_start;
    assign ld_busy  = r_busy;
    assign ld_sel   = r_sel;
    assign ld_field = r_field;

endmodule
`default_nettype wire

// File: tb/tb_rsa_op_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_op_loader
//  Purpose  : Self-checking bench for rsa_op_loader (NBYTES=2, DEB_CYCLES=4).
//             Uses a table of known entries, hand-written corner sequences,
//             and random entries. All of these are checked against an
//             operand/progress model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rsa_op_loader;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int W   = 8 * NB;
`ifdef RSA_LD_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT = 3;
    localparam bit DEB_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   din = 8'h00;
    logic         btn = 1'b0;
    logic         done = 1'b0;
    logic [W-1:0] m, e, n;
    logic         start, busy, sel;
    logic [1:0]   field;

    rsa_op_loader #(.NBYTES(NB), .DEB_CYCLES(DEB)) dut (
        .ld_clk(clk), .ld_rst(rst), .ld_din(din), .ld_btn(btn), .ld_done(done),
        .ld_m(m), .ld_e(e), .ld_n(n), .ld_start(start), .ld_busy(busy),
        .ld_sel(sel), .ld_field(field)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int starts_seen = 0;
    int sels_seen   = 0;
    int exp_starts  = 0;
    int exp_sels    = 0;

    always @(negedge clk) begin
        if (start) starts_seen++;
        if (sel)   sels_seen++;
    end

    // Reference model: bytes entered so far and whether a run is in progress.
    logic [W-1:0] em, ee, en;
    int           mcnt;
    bit           mrun;

    function automatic void model_reset();
        em = '0; ee = '0; en = '0; mcnt = 0; mrun = 1'b0;
    endfunction

    function automatic void model_capture(input logic [7:0] d);
        if (!mrun) begin
            case (mcnt / NB)
                0:       em = (em << 8) | W'(d);
                1:       ee = (ee << 8) | W'(d);
                default: en = (en << 8) | W'(d);
            endcase
            mcnt++;
            if (mcnt == 3 * NB) begin
                mcnt = 0;
                mrun = 1'b1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".m"}, 32'(m), 32'(em));
        chk({tag, ".e"}, 32'(e), 32'(ee));
        chk({tag, ".n"}, 32'(n), 32'(en));
        chk({tag, ".field"}, 32'(field), mrun ? 32'd3 : 32'(mcnt / NB));
        chk({tag, ".busy"}, 32'(busy), 32'(mrun));
    endtask

    // Hold the button and check that the capture lands exactly LAT edges
    // after the stable high is first sampled. The button is left pressed.
    task automatic press(input logic [7:0] d, input bit bounce);
        @(negedge clk);
        din = d;
        if (bounce) begin
            repeat (3) begin
                btn = 1'b1;
                repeat (2) @(negedge clk);
                btn = 1'b0;
                repeat (2) @(negedge clk);
            end
        end
        btn = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1 check_all("pre_capture");
        @(posedge clk);
        #1;
        model_capture(d);
        check_all("capture");
    endtask

    task automatic release_btn();
        @(negedge clk);
        btn = 1'b0;
        repeat (LAT + 2) @(posedge clk);
        #1 check_all("release");
    endtask

    task automatic enter_byte(input logic [7:0] d, input bit bounce);
        bit was_run;
        was_run = mrun;
        press(d, bounce);
        if (!was_run && mrun) begin
            chk("start_before", 32'(start), 32'd0);
            @(posedge clk); #1 chk("start_pulse", 32'(start), 32'd1);
            @(posedge clk); #1 chk("start_after", 32'(start), 32'd0);
            exp_starts++;
        end
        release_btn();
    endtask

    task automatic finish_run(input int delay);
        repeat (delay) @(negedge clk);
        chk("busy_before_done", 32'(busy), 32'd1);
        @(negedge clk) done = 1'b1;
        @(posedge clk); #1;
        mrun = 1'b0;
        chk("sel_pulse", 32'(sel), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("field_after_done", 32'(field), 32'd0);
        exp_sels++;
        @(negedge clk) done = 1'b0;
        @(posedge clk); #1 chk("sel_after", 32'(sel), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".m"}, 32'(m), 32'd0);
        chk({tag, ".e"}, 32'(e), 32'd0);
        chk({tag, ".n"}, 32'(n), 32'd0);
        chk({tag, ".start"}, 32'(start), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".sel"}, 32'(sel), 32'd0);
        chk({tag, ".field"}, 32'(field), 32'd0);
    endtask

    typedef struct {
        logic [47:0] bytes;   // entry order: [47:40] first
        logic [15:0] m, e, n;
    } vec_t;

    vec_t tbl[3];

    initial begin
        int s0;
        logic [7:0] b;
        logic [47:0] bb;

        tbl[0] = '{48'h1234_0011_0CA1, 16'h1234, 16'h0011, 16'h0CA1};
        tbl[1] = '{48'hFF00_8001_ABCD, 16'hFF00, 16'h8001, 16'hABCD};
        tbl[2] = '{48'h0000_FFFF_5AA5, 16'h0000, 16'hFFFF, 16'h5AA5};

        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Table-driven entries, with a busy-state press and completion.
        for (int i = 0; i < 3; i++) begin
            bb = tbl[i].bytes;
            for (int k = 0; k < 6; k++) begin
                b = bb[47 - 8*k -: 8];
                enter_byte(b, DEB_ON && (i == 0) && (k == 0));
            end
            chk("tbl.m", 32'(m), 32'(tbl[i].m));
            chk("tbl.e", 32'(e), 32'(tbl[i].e));
            chk("tbl.n", 32'(n), 32'(tbl[i].n));
            enter_byte(8'hFF, 1'b0);      // discarded while BUSY
            finish_run(i + 1);
        end

        // ld_done during LOAD_E is ignored.
        enter_byte(8'hA5, 1'b0);
        enter_byte(8'h5A, 1'b0);
        @(negedge clk) done = 1'b1;
        @(negedge clk) done = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("done_in_load.sel", 32'(sel), 32'd0);
        check_all("done_in_load");
        for (int k = 0; k < 4; k++) enter_byte(8'(k * 16 + 3), 1'b0);
        finish_run(2);

        // Reset while BUSY.
        for (int k = 0; k < 6; k++) enter_byte(8'($urandom_range(0, 255)), 1'b0);
        s0 = starts_seen;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 check_zero("rst_busy");
        @(negedge clk) rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk("rst_busy.nosel", 32'(sels_seen), 32'(exp_sels));

        // Reset during the START cycle: no start pulse may appear.
        for (int k = 0; k < 5; k++) enter_byte(8'($urandom_range(0, 255)), 1'b0);
        s0 = starts_seen;
        press(8'h77, 1'b0);
        rst = 1'b1;
        btn = 1'b0;
        @(posedge clk); #1 check_zero("rst_start");
        repeat (LAT + 3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1 chk("rst_start.nostart", 32'(starts_seen), 32'(s0));
        check_all("rst_start.after");

        // Randomized entries against the model.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 6; k++) enter_byte(8'($urandom_range(0, 255)), 1'b0);
            finish_run(int'($urandom_range(0, 5)));
            check_all("rand");
        end

        chk("start_count", 32'(starts_seen), 32'(exp_starts));
        chk("sel_count", 32'(sels_seen), 32'(exp_sels));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rsa_op_loader.md
# rsa_op_loader

Operand entry controller for the RSA demo board: reads the 8-bit toggle switches one byte per debounced pushbutton press and assembles the message (M), exponent (E) and modulus (N) operands for the RSA core. Once all three are loaded it starts the core, waits for completion, then pulses the select line that switches the 7-segment display multiplexer from the switches to the result. It is the input-side counterpart of the display I/O controller and drives that block's select input.

## Interface

Parameters:
- NBYTES, 1: bytes per operand; operand width W = 8*NBYTES; must be at least 1.
- DEB_CYCLES, 16: consecutive stable samples required to accept a button level change; must be at least 2.

Ports:
- ld_clk  in  1  system clock; all logic on rising edge.
- ld_rst  in  1  reset, synchronous, active-high.
- ld_din  in  8  toggle switches (asynchronous to ld_clk, sampled on capture only).
- ld_btn  in  1  load pushbutton, active-high, asynchronous, bouncy.
- ld_done  in  1  core completion; level or pulse, sampled only in BUSY.
- ld_m  out  W  message operand.
- ld_e  out  W  exponent operand.
- ld_n  out  W  modulus operand.
- ld_start  out  1  one-cycle core start pulse.
- ld_busy  out  1  high in START and BUSY.
- ld_sel  out  1  one-cycle pulse to the display controller select input.
- ld_field  out  2  current field: 0=M, 1=E, 2=N, 3=run.

## Operation

- Button path: 2-flop synchronizer -> debouncer -> rising-edge detect -> internal accept pulse `acc`.
- Debouncer: stable level q (reset 0), counter cnt (reset 0). Synced sample == q -> cnt <= 0. Otherwise cnt increments; on the cycle with cnt == DEB_CYCLES-1, q <= sample and cnt <= 0. acc = q & ~q_prev.
- Capture on acc in a LOAD state: selected field <= {field[W-9:0], ld_din} (MSB byte first); byte index increments. On acc with index == NBYTES-1: index <= 0, advance field.
- States: LOAD_M -> LOAD_E -> LOAD_N -> START -> BUSY -> LOAD_M.
  - LOAD_x: wait for acc as above.
  - START: one cycle; ld_start = 1; go to BUSY.
  - BUSY: on ld_done = 1, ld_sel = 1 for that cycle's registered output, go to LOAD_M with index 0.
- acc in START/BUSY is discarded (no capture, no index change). ld_done outside BUSY is ignored.
- Operand registers hold their values after the run; the next entry overwrites them byte by byte, and the core sees partially updated operands only while not started.
- ld_field = 3 in START and BUSY.

## Timing

- Reset values: ld_m = ld_e = ld_n = 0, ld_start = 0, ld_busy = 0, ld_sel = 0, ld_field = 0, state LOAD_M, index 0, synchronizer, q and cnt at 0.
- Reset asserted mid-operation (including during START or BUSY) returns all of the above at the next edge. A pending ld_start or ld_sel is not emitted.
- With debouncing enabled, for a clean high on ld_btn first sampled at edge 1, the capture register updates at edge DEB_CYCLES+3. Release is debounced the same way. A bounce shorter than DEB_CYCLES samples produces no acc.
- Last byte of N captured at edge k: ld_field = 3 and ld_busy = 1 after edge k; ld_start is high for exactly the cycle after edge k+1.
- ld_done high sampled at edge j in BUSY: ld_sel is high for one cycle after edge j; ld_busy = 0 and ld_field = 0 after edge j.
- All outputs are registered.

## Configuration

- RSA_LD_DEBOUNCE_EN defined: the debouncer operates as described.
- RSA_LD_DEBOUNCE_EN undefined: the debouncer is removed, q = synchronized sample, and the capture register updates at edge 3. DEB_CYCLES is ignored. All other behaviour is identical.

## Test plan

- NBYTES=2, DEB_CYCLES=4, debounce on. Enter bytes 0x12,0x34 / 0x00,0x11 / 0x0C,0xA1 with clean presses -> ld_m=0x1234, ld_e=0x0011, ld_n=0x0CA1. ld_start is a single pulse one cycle after the final capture, and ld_field sequences 0,1,2,3.
- Bouncy press: three 2-cycle glitches, then a stable high -> exactly one capture, DEB_CYCLES+3 edges after the stable high begins.
- In BUSY, press the button with ld_din=0xFF -> operands unchanged. Assert ld_done -> one-cycle ld_sel, then ld_busy=0 and ld_field=0.
- ld_done pulsed during LOAD_E -> no state change and no ld_sel.
- Assert ld_rst during BUSY and during the START cycle -> all outputs return to 0 at the next edge, and no ld_start or ld_sel is emitted.
- Debounce off, NBYTES=1 -> each clean press captures at edge 3, and a full M/E/N entry yields ld_start.
